// File: rtl/capture_pkg.sv
// Shared constants, id-width helper and bank state type for the capture bank controllers.
package capture_pkg;

    localparam int DEFAULT_NREQ = 4;
    localparam int DEFAULT_DW   = 32;

    // Bits needed to encode an index in 0..n-1, never less than one.
    function automatic int idw_for(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_state_t;

endpackage

// File: rtl/capture_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping at NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int   cand;
    logic found;

    assign any = |req;

    // ptr is always below NREQ, so a single subtraction gives the modulo.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/capture_bank_arbiter.sv
// Round-robin arbiter sharing one registered capture bank between NREQ requesters,
// presenting the captured word downstream over valid/ready.
module capture_bank_arbiter
    import capture_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int DW   = DEFAULT_DW,
    parameter int IDW  = idw_for(NREQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]  ack,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [IDW-1:0]   out_src,
    output logic             busy
);

    logic [DW-1:0]   words [NREQ];
    bank_state_t     state_reg;
    logic [DW-1:0]   out_data_reg;
    logic [IDW-1:0]  out_src_reg;
    logic [IDW-1:0]  ptr_reg;
    logic [IDW-1:0]  ptr_next;
    logic [IDW-1:0]  win;
    logic [NREQ-1:0] grant;
    logic            any_req;
    logic            load;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign words[gi] = req_data[gi*DW +: DW];
        end
    endgenerate

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .grant (grant),
        .idx   (win),
        .any   (any_req)
    );

    assign out_valid = (state_reg == FULL);
    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;
    assign busy      = out_valid | any_req;

    // A consumed word frees the bank in the same cycle, so loads continue without a bubble.
    assign load     = any_req & (~out_valid | out_ready);
    assign ack      = (load & ~reset) ? grant : '0;
    assign ptr_next = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= EMPTY;
            out_data_reg <= '0;
            out_src_reg  <= '0;
            ptr_reg      <= '0;
        end else if (load) begin
            state_reg    <= FULL;
            out_data_reg <= words[win];
            out_src_reg  <= win;
            ptr_reg      <= ptr_next;
        end else if (out_valid && out_ready) begin
            state_reg    <= EMPTY;
        end
    end

endmodule

// File: tb/tb_capture_bank_arbiter.sv
// Self-checking bench for capture_bank_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural round-robin / holding-register model.
module tb_capture_bank_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]   ack;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_data;
    logic [IDW-1:0]    out_src;
    logic              busy;

    int checks = 0;
    int failures = 0;

    // Behavioural model of the bank and the rotating priority.
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic [IDW-1:0] m_src = '0;
    int            m_ptr = 0;

    always #5 clk = ~clk;

    capture_bank_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .busy      (busy)
    );

    function automatic int m_winner(input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++)
            if (r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] m_ack();
        int w;
        w = m_winner(req);
        if (reset || w < 0 || (m_valid && !out_ready)) return '0;
        return NREQ'(1 << w);
    endfunction

    task automatic m_step();
        int w;
        w = m_winner(req);
        if (reset) begin
            m_valid = 1'b0; m_data = '0; m_src = '0; m_ptr = 0;
        end else if (w >= 0 && (!m_valid || out_ready)) begin
            m_valid = 1'b1;
            m_data  = req_data[w*DW +: DW];
            m_src   = IDW'(w);
            m_ptr   = (w + 1) % NREQ;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // Samples the combinational outputs mid-cycle, then advances one edge (no comparisons here).
    task automatic run_cycle(output logic [NREQ-1:0] got_ack, output logic [NREQ-1:0] want_ack,
                             output logic got_busy, output logic want_busy);
        @(negedge clk);
        got_ack   = ack;
        want_ack  = m_ack();
        got_busy  = busy;
        want_busy = m_valid | (|req);
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        m_step();
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [NREQ-1:0] ga, wa;
        logic gb, wb;
        reset = 1'b1; req = '0; out_ready = 1'b0;
        run_cycle(ga, wa, gb, wb);
        checks++;
        if ({out_valid, out_data, out_src} !== {1'b0, 32'h0, 2'd0}) begin
            failures++;
            $display("FAIL reset_state: got v=%0b d=%h s=%0d expected v=0 d=0 s=0", out_valid, out_data, out_src);
        end
        // Load a word so the bank is full when reset hits.
        reset = 1'b0; req = 4'b0001; req_data[0*DW +: DW] = 32'hDEADBEEF;
        run_cycle(ga, wa, gb, wb);
        checks++;
        if (ga !== 4'b0001) begin failures++; $display("FAIL reset_preload_ack: got %b expected 0001", ga); end
        checks++;
        if ({out_valid, out_data} !== {1'b1, 32'hDEADBEEF}) begin
            failures++; $display("FAIL reset_preload_out: got v=%0b d=%h expected v=1 d=deadbeef", out_valid, out_data);
        end
        reset = 1'b1; req = 4'b0010; req_data[1*DW +: DW] = 32'h0BADF00D;
        run_cycle(ga, wa, gb, wb);
        checks++;
        if (ga !== 4'b0000) begin failures++; $display("FAIL reset_no_ack: got %b expected 0000", ga); end
        checks++;
        if ({out_valid, out_data, out_src} !== {1'b0, 32'h0, 2'd0}) begin
            failures++;
            $display("FAIL reset_mid_transfer: got v=%0b d=%h s=%0d expected v=0 d=0 s=0", out_valid, out_data, out_src);
        end
        // ptr must be back at 0: all requesting picks requester 0.
        reset = 1'b0; req = 4'b1111;
        run_cycle(ga, wa, gb, wb);
        checks++;
        if (ga !== 4'b0001) begin failures++; $display("FAIL reset_ptr_zero: got ack %b expected 0001", ga); end
        req = '0;
    endtask

    task automatic test_single_load();
        logic [NREQ-1:0] ga, wa;
        logic gb, wb;
        do_reset();
        req = 4'b0100; req_data[2*DW +: DW] = 32'h12345678; out_ready = 1'b0;
        run_cycle(ga, wa, gb, wb);
        checks++;
        if (ga !== 4'b0100) begin failures++; $display("FAIL single_ack: got %b expected 0100", ga); end
        checks++;
        if ({out_valid, out_data, out_src} !== {1'b1, 32'h12345678, 2'd2}) begin
            failures++;
            $display("FAIL single_out: got v=%0b d=%h s=%0d expected v=1 d=12345678 s=2", out_valid, out_data, out_src);
        end
        req = '0;
        run_cycle(ga, wa, gb, wb);
        checks++;
        if (ga !== 4'b0000) begin failures++; $display("FAIL single_ack_once: got %b expected 0000", ga); end
    endtask

    task automatic test_backpressure();
        logic [NREQ-1:0] ga, wa;
        logic gb, wb;
        req = 4'b0001; req_data[0*DW +: DW] = 32'hA5A5A5A5; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_cycle(ga, wa, gb, wb);
            checks++;
            if (ga !== 4'b0000 || out_data !== 32'h12345678 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: got ack=%b v=%0b d=%h expected ack=0000 v=1 d=12345678", i, ga, out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        run_cycle(ga, wa, gb, wb);
        checks++;
        if (ga !== 4'b0001) begin failures++; $display("FAIL backpressure_release_ack: got %b expected 0001", ga); end
        checks++;
        if ({out_valid, out_data, out_src} !== {1'b1, 32'hA5A5A5A5, 2'd0}) begin
            failures++;
            $display("FAIL backpressure_release_out: got v=%0b d=%h s=%0d expected v=1 d=a5a5a5a5 s=0", out_valid, out_data, out_src);
        end
        req = '0; out_ready = 1'b0;
    endtask

    task automatic test_rotation();
        logic [NREQ-1:0] ga, wa;
        logic gb, wb;
        do_reset();
        for (int k = 0; k < NREQ; k++) req_data[k*DW +: DW] = $urandom();
        req = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_cycle(ga, wa, gb, wb);
            checks++;
            if (ga !== NREQ'(1 << (i % NREQ))) begin
                failures++; $display("FAIL rotation_ack[%0d]: got %b expected %b", i, ga, NREQ'(1 << (i % NREQ)));
            end
            checks++;
            if (out_src !== IDW'(i % NREQ) || out_data !== req_data[(i % NREQ)*DW +: DW] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL rotation_out[%0d]: got v=%0b s=%0d d=%h expected v=1 s=%0d d=%h", i, out_valid, out_src, out_data,
                         i % NREQ, req_data[(i % NREQ)*DW +: DW]);
            end
        end
        req = '0;
    endtask

    task automatic test_wrap_skip();
        logic [NREQ-1:0] ga, wa;
        logic gb, wb;
        logic [NREQ-1:0] stim [4];
        logic [NREQ-1:0] want [4];
        stim = '{4'b0100, 4'b0011, 4'b0010, 4'b1111};
        want = '{4'b0100, 4'b0001, 4'b0010, 4'b0100};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req = stim[i];
            run_cycle(ga, wa, gb, wb);
            checks++;
            if (ga !== want[i]) begin failures++; $display("FAIL wrap_skip_ack[%0d]: got %b expected %b", i, ga, want[i]); end
        end
        req = '0;
    endtask

    task automatic test_drain();
        logic [NREQ-1:0] ga, wa;
        logic gb, wb;
        req = '0; out_ready = 1'b1;
        run_cycle(ga, wa, gb, wb);
        checks++;
        if (gb !== 1'b1) begin failures++; $display("FAIL drain_busy_before: got %0b expected 1", gb); end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL drain_after: got v=%0b busy=%0b expected v=0 busy=0", out_valid, busy);
        end
        checks++;
        if (out_data !== m_data) begin failures++; $display("FAIL drain_data_kept: got %h expected %h", out_data, m_data); end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] ga, wa;
        logic gb, wb;
        int waitc [NREQ];
        for (int k = 0; k < NREQ; k++) waitc[k] = 0;
        do_reset();
        req = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            run_cycle(ga, wa, gb, wb);
            checks++;
            if (ga !== wa) begin failures++; $display("FAIL random_ack[%0d]: got %b expected %b", cyc, ga, wa); end
            checks++;
            if (gb !== wb) begin failures++; $display("FAIL random_busy[%0d]: got %0b expected %0b", cyc, gb, wb); end
            checks++;
            if ({out_valid, out_data, out_src} !== {m_valid, m_data, m_src}) begin
                failures++;
                $display("FAIL random_out[%0d]: got v=%0b d=%h s=%0d expected v=%0b d=%h s=%0d", cyc, out_valid, out_data, out_src,
                         m_valid, m_data, m_src);
            end
            for (int k = 0; k < NREQ; k++) begin
                if (req[k] && ga[k]) begin
                    checks++;
                    if (waitc[k] > NREQ - 1) begin
                        failures++; $display("FAIL random_fairness[%0d]: requester %0d waited %0d loads, limit %0d", cyc, k, waitc[k], NREQ - 1);
                    end
                    waitc[k] = 0;
                    req[k] = 1'($urandom_range(0, 1));
                    if (req[k]) req_data[k*DW +: DW] = $urandom();
                end else if (req[k]) begin
                    if (|ga) waitc[k]++;
                end else if ($urandom_range(0, 2) == 0) begin
                    req[k] = 1'b1;
                    req_data[k*DW +: DW] = $urandom();
                    waitc[k] = 0;
                end
            end
        end
        req = '0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_backpressure();
        test_rotation();
        test_wrap_skip();
        test_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
